// File: rtl/bm_map_pkg.sv
// Shared constants, state encoding and helpers for the block_map write controller.
package bm_map_pkg;

  localparam int ADDR_W = 10;
  localparam int LFSR_W = 16;

  // Playfield geometry; cells are addressed as col + row*MAP_COLS.
  localparam logic [5:0]        MAP_COLS  = 6'd33;
  localparam logic [4:0]        MAP_ROWS  = 5'd26;
  localparam logic [ADDR_W-1:0] MAP_CELLS = 10'd858;

  // Reserved address beyond the playfield, never a real cell.
  localparam logic [ADDR_W-1:0] DONT_CARE_ADDR = 10'd896;

  // Cells around the bomberman spawn point that must stay free.
  localparam logic [ADDR_W-1:0] SPAWN_ADDR_0 = 10'd0;
  localparam logic [ADDR_W-1:0] SPAWN_ADDR_1 = 10'd1;
  localparam logic [ADDR_W-1:0] SPAWN_ADDR_2 = 10'd33;

  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN
  } state_e;

  // Fibonacci LFSR step: shift left, XOR of the tapped bits enters bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

  function automatic logic is_spawn_safe(input logic [ADDR_W-1:0] addr);
    return (addr == SPAWN_ADDR_0) || (addr == SPAWN_ADDR_1) || (addr == SPAWN_ADDR_2);
  endfunction

endpackage

// File: rtl/block_map_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible request at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [N-1:0] eligible;
  logic         found;
  int           cand;

  assign eligible = req & ~mask;

  // Walk the requesters starting at ptr, wrapping modulo N, and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/block_map_ctrl.sv
// Write-side controller for block_map: random layout sweep at start, then
// round-robin arbitration of block-clear requests onto the single write port.
module block_map_ctrl
  import bm_map_pkg::*;
#(
  parameter int          N_REQ   = 4,
  parameter logic [8:0]  DENSITY = 9'd96,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N_REQ-1:0]        req,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  output logic [N_REQ-1:0]        ack,
  output logic [ADDR_W-1:0]       waddr,
  output logic                    we,
  output logic                    wdata,
  output logic                    busy,
  output logic                    init_done,
  output logic                    clr_valid,
  output logic [ADDR_W-1:0]       clr_addr
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [5:0]          col_q, col_d;
  logic [4:0]          row_q, row_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                we_q, we_d;
  logic                wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                init_done_q, init_done_d;
  logic                clr_valid_q, clr_valid_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

  logic [N_REQ-1:0]    grant;
  logic [PTR_W-1:0]    grant_idx;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                block_bit;

  // Requesters acked this cycle are masked so a still-high req is not granted twice.
  rr_arbiter #(
    .N  (N_REQ),
    .IW (PTR_W)
  ) u_arb (
    .req       (req),
    .mask      (ack_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign gnt_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign block_bit = ({1'b0, lfsr_q[7:0]} < DENSITY)
                   && !(col_q[0] && row_q[0])
                   && !is_spawn_safe(cnt_q);

  // Next-state and next-output logic for the IDLE/INIT/RUN controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    lfsr_d      = lfsr_q;
    rr_ptr_d    = rr_ptr_q;
    ack_d       = '0;
    waddr_d     = waddr_q;
    we_d        = 1'b0;
    wdata_d     = 1'b0;
    busy_d      = 1'b0;
    init_done_d = init_done_q;
    clr_valid_d = 1'b0;
    clr_addr_d  = clr_addr_q;

    case (state_q)
      ST_INIT: begin
        if (cnt_q < MAP_CELLS) begin
          we_d    = 1'b1;
          busy_d  = 1'b1;
          waddr_d = cnt_q;
          wdata_d = block_bit;
          lfsr_d  = lfsr_next(lfsr_q);
          cnt_d   = cnt_q + ADDR_W'(1);
          if (col_q == MAP_COLS - 6'd1) begin
            col_d = '0;
            row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 6'd1;
          end
        end else begin
          init_done_d = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!start && (|grant)) begin
          ack_d    = grant;
          rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
          if (gnt_addr < MAP_CELLS) begin
            we_d        = 1'b1;
            waddr_d     = gnt_addr;
            clr_valid_d = 1'b1;
            clr_addr_d  = gnt_addr;
          end
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      col_d   = '0;
      row_d   = '0;
      lfsr_d  = SEED;
    end
  end

  // State, counters, LFSR and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      lfsr_q      <= SEED;
      rr_ptr_q    <= '0;
      ack_q       <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      clr_valid_q <= 1'b0;
      clr_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lfsr_q      <= lfsr_d;
      rr_ptr_q    <= rr_ptr_d;
      ack_q       <= ack_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      clr_valid_q <= clr_valid_d;
      clr_addr_q  <= clr_addr_d;
    end
  end

  assign ack       = ack_q;
  assign waddr     = waddr_q;
  assign we        = we_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign clr_valid = clr_valid_q;
  assign clr_addr  = clr_addr_q;

endmodule

// File: tb/tb_block_map_ctrl.sv
// Bench for block_map_ctrl: three instances (density 96, 256 and 0) share stimulus.
module tb_block_map_ctrl;

  localparam logic [15:0] SEED_V = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  req;
  logic [39:0] req_addr;

  logic [3:0] ack,   ack_f,   ack_z;
  logic [9:0] waddr, waddr_f, waddr_z;
  logic       we,    we_f,    we_z;
  logic       wdata, wdata_f, wdata_z;
  logic       busy,  busy_f,  busy_z;
  logic       init_done, init_done_f, init_done_z;
  logic       clr_valid, clr_valid_f, clr_valid_z;
  logic [9:0] clr_addr,  clr_addr_f,  clr_addr_z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [39:0] addrs;
    logic [3:0]  exp_ack;
    logic        exp_we;
    logic [9:0]  exp_waddr;
    logic        exp_clr_valid;
  } vec_t;

  vec_t vecs [18];

  always #5 clk = ~clk;

  block_map_ctrl #(.N_REQ(4), .DENSITY(9'd96), .SEED(SEED_V)) dut (
    .clk(clk), .reset(rst_n), .start(start), .req(req), .req_addr(req_addr),
    .ack(ack), .waddr(waddr), .we(we), .wdata(wdata), .busy(busy),
    .init_done(init_done), .clr_valid(clr_valid), .clr_addr(clr_addr));

  block_map_ctrl #(.N_REQ(4), .DENSITY(9'd256), .SEED(SEED_V)) dut_full (
    .clk(clk), .reset(rst_n), .start(start), .req(req), .req_addr(req_addr),
    .ack(ack_f), .waddr(waddr_f), .we(we_f), .wdata(wdata_f), .busy(busy_f),
    .init_done(init_done_f), .clr_valid(clr_valid_f), .clr_addr(clr_addr_f));

  block_map_ctrl #(.N_REQ(4), .DENSITY(9'd0), .SEED(SEED_V)) dut_zero (
    .clk(clk), .reset(rst_n), .start(start), .req(req), .req_addr(req_addr),
    .ack(ack_z), .waddr(waddr_z), .we(we_z), .wdata(wdata_z), .busy(busy_z),
    .init_done(init_done_z), .clr_valid(clr_valid_z), .clr_addr(clr_addr_z));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] r, input logic [39:0] a);
    start    = s;
    req      = r;
    req_addr = a;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One full sweep, checked cell by cell against an independent layout model.
  task automatic runSweep(input int sweep_no, input bit hold_req1);
    logic [15:0] ml;
    int row, col;
    bit pillar, spawn, e96, efull;
    ml = SEED_V;
    if (hold_req1) applyStimulus(1'b1, 4'b0010, {10'd0, 10'd0, 10'd5, 10'd0});
    else           applyStimulus(1'b1, 4'b0000, 40'd0);
    step();
    start = 1'b0;
    checkOutput("start_cycle_ack", {28'd0, ack}, 32'd0);
    checkOutput("start_cycle_we", {31'd0, we}, 32'd0);
    for (int n = 0; n < 858; n++) begin
      step();
      row    = n / 33;
      col    = n % 33;
      pillar = (row % 2 == 1) && (col % 2 == 1);
      spawn  = (n == 0) || (n == 1) || (n == 33);
      efull  = !pillar && !spawn;
      e96    = (ml[7:0] < 8'd96) && efull;
      checkOutput("sweep_we", {31'd0, we}, 32'd1);
      checkOutput("sweep_waddr", {22'd0, waddr}, n);
      checkOutput("sweep_busy", {31'd0, busy}, 32'd1);
      checkOutput("sweep_ack", {28'd0, ack}, 32'd0);
      checkOutput("sweep_wdata_d96", {31'd0, wdata}, {31'd0, e96});
      checkOutput("sweep_wdata_d256", {31'd0, wdata_f}, {31'd0, efull});
      checkOutput("sweep_wdata_d0", {31'd0, wdata_z}, 32'd0);
      checkOutput("sweep_we_d0", {31'd0, we_z}, 32'd1);
      if (sweep_no == 1) begin
        if (n == 0 || n == 1 || n == 33 || n == 34 || n == 36 || n == 100)
          checkOutput("spot_wdata_zero", {31'd0, wdata_f}, 32'd0);
        if (n == 2)
          checkOutput("spot_wdata_two", {31'd0, wdata_f}, 32'd1);
        if (n == 857)
          checkOutput("init_done_before_end", {31'd0, init_done}, 32'd0);
      end
      ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
    end
    step();
    checkOutput("end_we", {31'd0, we}, 32'd0);
    checkOutput("end_busy", {31'd0, busy}, 32'd0);
    checkOutput("end_init_done", {31'd0, init_done}, 32'd1);
    checkOutput("end_wdata", {31'd0, wdata}, 32'd0);
  endtask

  initial begin
    bit found;

    // Round-robin vectors; ack of the previous row masks that arm in this row.
    vecs[0]  = '{4'b1111, {10'd40, 10'd30, 10'd20, 10'd10}, 4'b0001, 1'b1, 10'd10,  1'b1};
    vecs[1]  = '{4'b1111, {10'd40, 10'd30, 10'd20, 10'd10}, 4'b0010, 1'b1, 10'd20,  1'b1};
    vecs[2]  = '{4'b1110, {10'd40, 10'd30, 10'd20, 10'd10}, 4'b0100, 1'b1, 10'd30,  1'b1};
    vecs[3]  = '{4'b1100, {10'd40, 10'd30, 10'd20, 10'd10}, 4'b1000, 1'b1, 10'd40,  1'b1};
    vecs[4]  = '{4'b1000, {10'd40, 10'd30, 10'd20, 10'd10}, 4'b0000, 1'b0, 10'd0,   1'b0};
    vecs[5]  = '{4'b0100, {10'd0,  10'd900, 10'd0, 10'd0},  4'b0100, 1'b0, 10'd0,   1'b0};
    vecs[6]  = '{4'b0100, {10'd0,  10'd900, 10'd0, 10'd0},  4'b0000, 1'b0, 10'd0,   1'b0};
    vecs[7]  = '{4'b0100, {10'd0,  10'd857, 10'd0, 10'd0},  4'b0100, 1'b1, 10'd857, 1'b1};
    vecs[8]  = '{4'b0000, 40'd0,                            4'b0000, 1'b0, 10'd0,   1'b0};
    vecs[9]  = '{4'b0001, {10'd0,  10'd0,  10'd0, 10'd10},  4'b0001, 1'b1, 10'd10,  1'b1};
    vecs[10] = '{4'b0001, {10'd0,  10'd0,  10'd0, 10'd10},  4'b0000, 1'b0, 10'd0,   1'b0};
    vecs[11] = '{4'b0001, {10'd0,  10'd0,  10'd0, 10'd12},  4'b0001, 1'b1, 10'd12,  1'b1};
    vecs[12] = '{4'b0000, 40'd0,                            4'b0000, 1'b0, 10'd0,   1'b0};
    vecs[13] = '{4'b0010, {10'd0,  10'd0,  10'd858, 10'd0}, 4'b0010, 1'b0, 10'd0,   1'b0};
    vecs[14] = '{4'b0000, 40'd0,                            4'b0000, 1'b0, 10'd0,   1'b0};
    vecs[15] = '{4'b1001, {10'd41, 10'd0,  10'd0, 10'd11},  4'b1000, 1'b1, 10'd41,  1'b1};
    vecs[16] = '{4'b1001, {10'd41, 10'd0,  10'd0, 10'd11},  4'b0001, 1'b1, 10'd11,  1'b1};
    vecs[17] = '{4'b0000, 40'd0,                            4'b0000, 1'b0, 10'd0,   1'b0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 4'b0000, 40'd0);
    step();
    step();
    checkOutput("rst_ack", {28'd0, ack}, 32'd0);
    checkOutput("rst_waddr", {22'd0, waddr}, 32'd0);
    checkOutput("rst_we", {31'd0, we}, 32'd0);
    checkOutput("rst_wdata", {31'd0, wdata}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("rst_clr_valid", {31'd0, clr_valid}, 32'd0);
    checkOutput("rst_clr_addr", {22'd0, clr_addr}, 32'd0);
    rst_n = 1'b1;

    // IDLE ignores requests.
    applyStimulus(1'b0, 4'b1111, {10'd4, 10'd3, 10'd2, 10'd1});
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("idle_ack", {28'd0, ack}, 32'd0);
      checkOutput("idle_we", {31'd0, we}, 32'd0);
      checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    end
    applyStimulus(1'b0, 4'b0000, 40'd0);

    $display("[TB] sweep 1 from IDLE");
    runSweep(1, 1'b0);
    $display("[TB] sweep 2 from RUN, same seed");
    runSweep(2, 1'b0);

    $display("[TB] round-robin vector table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, vecs[i].req, vecs[i].addrs);
      step();
      checkOutput($sformatf("vec%0d_ack", i), {28'd0, ack}, {28'd0, vecs[i].exp_ack});
      checkOutput($sformatf("vec%0d_we", i), {31'd0, we}, {31'd0, vecs[i].exp_we});
      checkOutput($sformatf("vec%0d_wdata", i), {31'd0, wdata}, 32'd0);
      checkOutput($sformatf("vec%0d_clr_valid", i), {31'd0, clr_valid}, {31'd0, vecs[i].exp_clr_valid});
      if (vecs[i].exp_we) begin
        checkOutput($sformatf("vec%0d_waddr", i), {22'd0, waddr}, {22'd0, vecs[i].exp_waddr});
        checkOutput($sformatf("vec%0d_clr_addr", i), {22'd0, clr_addr}, {22'd0, vecs[i].exp_waddr});
      end
    end

    $display("[TB] sweep 3 with req[1] pending through INIT");
    runSweep(3, 1'b1);
    step();
    checkOutput("pending_ack", {28'd0, ack}, 32'd2);
    checkOutput("pending_we", {31'd0, we}, 32'd1);
    checkOutput("pending_waddr", {22'd0, waddr}, 32'd5);
    checkOutput("pending_clr_valid", {31'd0, clr_valid}, 32'd1);
    applyStimulus(1'b0, 4'b0000, 40'd0);
    step();

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(1'b1, 4'b0000, 40'd0);
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (we && waddr == 10'd400) found = 1'b1;
    end
    checkOutput("reach_cnt400", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_we", {31'd0, we}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("async_rst_waddr", {22'd0, waddr}, 32'd0);
    step();
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0000, 40'd0);
    step();
    start = 1'b0;
    step();
    checkOutput("restart_we", {31'd0, we}, 32'd1);
    checkOutput("restart_waddr0", {22'd0, waddr}, 32'd0);
    checkOutput("restart_busy", {31'd0, busy}, 32'd1);
    checkOutput("restart_init_done", {31'd0, init_done}, 32'd0);
    step();
    checkOutput("restart_waddr1", {22'd0, waddr}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
